// File: rtl/mdio_c45_responder.sv
// Clause-45 MDIO responder: oversamples MDC/MDIO on REFCLK, decodes ADDRESS/WRITE/READ/PRI
// frames and serves a small register file back on MDIO.
//
// state   | meaning
// --------|------------------------------------------------------------
// S_IDLE  | counting preamble 1s; a 0 after a full preamble is ST bit 1
// S_ST    | expecting ST bit 2 (0 = Clause 45, 1 = Clause 22 -> ignore)
// S_OP    | shifting the 2 opcode bits
// S_PRTAD | shifting the 5 port-address bits
// S_DEVAD | shifting the 5 device-address bits; read word captured at end
// S_TA    | turnaround; checked on writes, driven 0 on matched reads
// S_DATA  | 16 data bits; reads linger until the trailing MDC fall
module mdio_c45_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'h01,
    parameter logic [4:0] DEV_ADDR     = 5'h04,
    parameter int         NREG         = 16,
    parameter int         PREAMBLE_MIN = 32
) (
    input  logic        REFCLK,
    input  logic        async_reset,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        reg_wr,
    output logic [15:0] reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic [15:0] addr_reg,
    output logic        frame_err
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int PW = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_MIN);

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PRTAD, S_DEVAD, S_TA, S_DATA
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     mdc_s_q, mdc_s_d;
    logic [1:0]     mdio_s_q, mdio_s_d;
    logic [PW-1:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [15:0]    shift_q, shift_d;
    logic [1:0]     op_q, op_d;
    logic [4:0]     prtad_q, prtad_d;
    logic           match_q, match_d;
    logic           ta_err_q, ta_err_d;
    logic [15:0]    rd_word_q, rd_word_d;
    logic [15:0]    addr_reg_q, addr_reg_d;
    logic [15:0]    regs_q [NREG];
    logic [15:0]    regs_d [NREG];
    logic           reg_wr_q, reg_wr_d;
    logic [15:0]    reg_wr_addr_q, reg_wr_addr_d;
    logic [15:0]    reg_wr_data_q, reg_wr_data_d;
    logic           frame_err_q, frame_err_d;
    logic           mdio_o_q, mdio_o_d;
    logic           mdio_oe_q, mdio_oe_d;

    logic           mdc_rise, mdc_fall, bit_in, addr_ok;
    logic [15:0]    data_word;

    assign mdc_rise = mdc_s_q[1] & ~mdc_s_q[2];
    assign mdc_fall = ~mdc_s_q[1] & mdc_s_q[2];
    assign bit_in   = mdio_s_q[1];

    always_ff @(posedge REFCLK or negedge async_reset) begin
        if (!async_reset) begin
            state_q       <= S_IDLE;
            mdc_s_q       <= '0;
            mdio_s_q      <= '0;
            pre_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            op_q          <= '0;
            prtad_q       <= '0;
            match_q       <= 1'b0;
            ta_err_q      <= 1'b0;
            rd_word_q     <= '0;
            addr_reg_q    <= '0;
            regs_q        <= '{default: '0};
            reg_wr_q      <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            frame_err_q   <= 1'b0;
            mdio_o_q      <= 1'b1;
            mdio_oe_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mdc_s_q       <= mdc_s_d;
            mdio_s_q      <= mdio_s_d;
            pre_cnt_q     <= pre_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            op_q          <= op_d;
            prtad_q       <= prtad_d;
            match_q       <= match_d;
            ta_err_q      <= ta_err_d;
            rd_word_q     <= rd_word_d;
            addr_reg_q    <= addr_reg_d;
            regs_q        <= regs_d;
            reg_wr_q      <= reg_wr_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            frame_err_q   <= frame_err_d;
            mdio_o_q      <= mdio_o_d;
            mdio_oe_q     <= mdio_oe_d;
        end
    end

    always_comb begin
        mdc_s_d       = {mdc_s_q[1:0], mdc};
        mdio_s_d      = {mdio_s_q[0], mdio_i};
        state_d       = state_q;
        pre_cnt_d     = pre_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        op_d          = op_q;
        prtad_d       = prtad_q;
        match_d       = match_q;
        ta_err_d      = ta_err_q;
        rd_word_d     = rd_word_q;
        addr_reg_d    = addr_reg_q;
        regs_d        = regs_q;
        reg_wr_d      = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        frame_err_d   = 1'b0;
        mdio_o_d      = mdio_o_q;
        mdio_oe_d     = mdio_oe_q;
        data_word     = {shift_q[14:0], bit_in};
        addr_ok       = (addr_reg_q < 16'(NREG));

        if (mdc_rise) begin
            shift_d = data_word;
            unique case (state_q)
                S_IDLE: begin
                    if (bit_in) begin
                        if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
                    end else begin
                        if (pre_cnt_q == PRE_MAX) state_d = S_ST;
                        pre_cnt_d = '0;
                    end
                end
                S_ST: begin
                    bit_cnt_d = '0;
                    state_d   = bit_in ? S_IDLE : S_OP;
                end
                S_OP: begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd1) begin
                        op_d      = data_word[1:0];
                        bit_cnt_d = '0;
                        state_d   = S_PRTAD;
                    end
                end
                S_PRTAD: begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd4) begin
                        prtad_d   = data_word[4:0];
                        bit_cnt_d = '0;
                        state_d   = S_DEVAD;
                    end
                end
                S_DEVAD: begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd4) begin
                        match_d   = (prtad_q == PHY_ADDR) && (data_word[4:0] == DEV_ADDR);
                        rd_word_d = addr_ok ? regs_q[addr_reg_q[AW-1:0]] : 16'hFFFF;
                        ta_err_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = S_TA;
                    end
                end
                S_TA: begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    // station-driven turnaround must read 1 then 0
                    if (!op_q[1] && (bit_in != (bit_cnt_q == 5'd0))) ta_err_d = 1'b1;
                    if (bit_cnt_q == 5'd1) begin
                        frame_err_d = ta_err_d;
                        bit_cnt_d   = '0;
                        state_d     = S_DATA;
                    end
                end
                S_DATA: begin
                    if (!bit_cnt_q[4]) bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) begin
                        if (match_q && !ta_err_q) begin
                            unique case (op_q)
                                2'b00: addr_reg_d = data_word;
                                2'b01: if (addr_ok) begin
                                    regs_d[addr_reg_q[AW-1:0]] = data_word;
                                    reg_wr_d      = 1'b1;
                                    reg_wr_addr_d = addr_reg_q;
                                    reg_wr_data_d = data_word;
                                end
                                2'b10: addr_reg_d = addr_reg_q + 16'd1;
                                default: ;
                            endcase
                        end
                        if (!op_q[1]) begin
                            bit_cnt_d = '0;
                            state_d   = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (mdc_fall) begin
            if (state_q == S_TA && bit_cnt_q == 5'd1 && op_q[1] && match_q) begin
                mdio_oe_d = 1'b1;
                mdio_o_d  = 1'b0;
            end else if (state_q == S_DATA) begin
                // bit_cnt[4] set means all 16 read bits have been sampled
                if (bit_cnt_q[4]) begin
                    mdio_oe_d = 1'b0;
                    mdio_o_d  = 1'b1;
                    bit_cnt_d = '0;
                    pre_cnt_d = '0;
                    state_d   = S_IDLE;
                end else if (op_q[1] && match_q) begin
                    mdio_o_d  = rd_word_q[15];
                    rd_word_d = {rd_word_q[14:0], 1'b0};
                end
            end
        end
    end

    assign mdio_o      = mdio_o_q;
    assign mdio_oe     = mdio_oe_q;
    assign reg_wr      = reg_wr_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign addr_reg    = addr_reg_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_mdio_c45_responder.sv
// Directed-vector bench for mdio_c45_responder: a station model drives MDC/MDIO frames
// from a table and checks register-file, pointer and read-back behaviour.
module tb_mdio_c45_responder;

    logic        REFCLK = 1'b0;
    logic        async_reset;
    logic        mdc;
    logic        st_oe, st_val;
    logic        mdio_pin;
    logic        mdio_o, mdio_oe, reg_wr, frame_err;
    logic [15:0] reg_wr_addr, reg_wr_data, addr_reg;

    int n_checks = 0;
    int n_err    = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    int oe_cyc   = 0;
    logic [15:0] last_wa = '0, last_wd = '0;

    always #5 REFCLK = ~REFCLK;

    assign mdio_pin = mdio_oe ? mdio_o : (st_oe ? st_val : 1'b1);

    mdio_c45_responder dut (
        .REFCLK     (REFCLK),
        .async_reset(async_reset),
        .mdc        (mdc),
        .mdio_i     (mdio_pin),
        .mdio_o     (mdio_o),
        .mdio_oe    (mdio_oe),
        .reg_wr     (reg_wr),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .addr_reg   (addr_reg),
        .frame_err  (frame_err)
    );

    always @(posedge REFCLK) begin
        if (reg_wr) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= reg_wr_addr;
            last_wd <= reg_wr_data;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (mdio_oe) oe_cyc <= oe_cyc + 1;
    end

    typedef struct {
        int          pre;
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  pa;
        logic [4:0]  da;
        logic [1:0]  ta;
        logic [15:0] data;
        logic [15:0] exp_rd;
        logic        exp_drive;
        int          exp_wr;
        int          exp_err;
        logic [15:0] exp_addr;
        logic [15:0] exp_wa;
        logic [15:0] exp_wd;
    } vec_t;

    localparam int NV = 31;
    vec_t v [NV];

    function automatic vec_t mk(input int pre, input logic [1:0] st, input logic [1:0] op,
                                input logic [4:0] pa, input logic [4:0] da, input logic [1:0] ta,
                                input logic [15:0] data, input logic [15:0] exp_rd,
                                input logic exp_drive, input int exp_wr, input int exp_err,
                                input logic [15:0] exp_addr, input logic [15:0] exp_wa,
                                input logic [15:0] exp_wd);
        vec_t t;
        t.pre = pre; t.st = st; t.op = op; t.pa = pa; t.da = da; t.ta = ta; t.data = data;
        t.exp_rd = exp_rd; t.exp_drive = exp_drive; t.exp_wr = exp_wr; t.exp_err = exp_err;
        t.exp_addr = exp_addr; t.exp_wa = exp_wa; t.exp_wd = exp_wd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clk_bit(input logic b);
        st_val = b;
        #50 mdc = 1'b1;
        #50 mdc = 1'b0;
    endtask

    task automatic frame(input vec_t t, output logic [15:0] rd, output logic ta1_oe,
                         output logic ta2_oe, output logic ta2_val);
        rd = '0; ta1_oe = 1'b0; ta2_oe = 1'b0; ta2_val = 1'b1;
        st_oe = 1'b1;
        repeat (t.pre) clk_bit(1'b1);
        clk_bit(t.st[1]); clk_bit(t.st[0]);
        clk_bit(t.op[1]); clk_bit(t.op[0]);
        for (int i = 4; i >= 0; i--) clk_bit(t.pa[i]);
        for (int i = 4; i >= 0; i--) clk_bit(t.da[i]);
        if (t.op[1]) begin
            st_oe = 1'b0;
            for (int i = 0; i < 18; i++) begin
                #45;
                if (i == 0) ta1_oe = mdio_oe;
                else if (i == 1) begin
                    ta2_oe  = mdio_oe;
                    ta2_val = mdio_pin;
                end else rd[17-i] = mdio_pin;
                #5 mdc = 1'b1;
                #50 mdc = 1'b0;
            end
        end else begin
            clk_bit(t.ta[1]); clk_bit(t.ta[0]);
            for (int i = 15; i >= 0; i--) clk_bit(t.data[i]);
        end
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        int wr0, err0, oe0;
        logic [15:0] rd;
        logic ta1_oe, ta2_oe, ta2_val, oe_end;
        wr0 = wr_cnt; err0 = err_cnt; oe0 = oe_cyc;
        frame(t, rd, ta1_oe, ta2_oe, ta2_val);
        #40;
        oe_end = mdio_oe;
        st_oe = 1'b1; st_val = 1'b1;
        chk($sformatf("v%0d addr_reg", idx), addr_reg, t.exp_addr);
        chk($sformatf("v%0d reg_wr count", idx), wr_cnt - wr0, t.exp_wr);
        chk($sformatf("v%0d frame_err count", idx), err_cnt - err0, t.exp_err);
        if (t.exp_wr != 0) begin
            chk($sformatf("v%0d reg_wr_addr", idx), last_wa, t.exp_wa);
            chk($sformatf("v%0d reg_wr_data", idx), last_wd, t.exp_wd);
        end
        if (t.exp_drive) begin
            chk($sformatf("v%0d ta1 oe", idx), ta1_oe, 1'b0);
            chk($sformatf("v%0d ta2 oe", idx), ta2_oe, 1'b1);
            chk($sformatf("v%0d ta2 value", idx), ta2_val, 1'b0);
            chk($sformatf("v%0d read data", idx), rd, t.exp_rd);
            chk($sformatf("v%0d oe after frame", idx), oe_end, 1'b0);
        end else begin
            chk($sformatf("v%0d oe cycles", idx), oe_cyc - oe0, 0);
        end
        #200;
    endtask

    // Abort a READ mid-data with reset, then require the pins to release at once.
    task automatic reset_seq();
        st_oe = 1'b1;
        repeat (32) clk_bit(1'b1);
        clk_bit(1'b0); clk_bit(1'b0); clk_bit(1'b1); clk_bit(1'b1);
        for (int i = 4; i >= 0; i--) clk_bit(1'(5'h01 >> i));
        for (int i = 4; i >= 0; i--) clk_bit(1'(5'h04 >> i));
        st_oe = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #50 mdc = 1'b1;
            #50 mdc = 1'b0;
        end
        #40;
        chk("rst oe before reset", mdio_oe, 1'b1);
        async_reset = 1'b0;
        #1;
        chk("rst oe", mdio_oe, 1'b0);
        chk("rst mdio_o", mdio_o, 1'b1);
        chk("rst addr_reg", addr_reg, 16'h0000);
        #20 async_reset = 1'b1;
        st_oe = 1'b1; st_val = 1'b1;
        #139;
    endtask

    initial begin
        v[0]  = mk(32, 2'b00, 2'b00, 5'h01, 5'h04, 2'b10, 16'h0003, 16'h0, 0, 0, 0, 16'h0003, 16'h0, 16'h0);
        v[1]  = mk(32, 2'b00, 2'b01, 5'h01, 5'h04, 2'b10, 16'hFEED, 16'h0, 0, 1, 0, 16'h0003, 16'h0003, 16'hFEED);
        v[2]  = mk(32, 2'b00, 2'b11, 5'h01, 5'h04, 2'b10, 16'h0000, 16'hFEED, 1, 0, 0, 16'h0003, 16'h0, 16'h0);
        v[3]  = mk(32, 2'b00, 2'b00, 5'h01, 5'h04, 2'b10, 16'h0000, 16'h0, 0, 0, 0, 16'h0000, 16'h0, 16'h0);
        v[4]  = mk(32, 2'b00, 2'b01, 5'h01, 5'h04, 2'b10, 16'h0001, 16'h0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0001);
        v[5]  = mk(32, 2'b00, 2'b00, 5'h01, 5'h04, 2'b10, 16'h0001, 16'h0, 0, 0, 0, 16'h0001, 16'h0, 16'h0);
        v[6]  = mk(32, 2'b00, 2'b01, 5'h01, 5'h04, 2'b10, 16'h0002, 16'h0, 0, 1, 0, 16'h0001, 16'h0001, 16'h0002);
        v[7]  = mk(32, 2'b00, 2'b00, 5'h01, 5'h04, 2'b10, 16'h0000, 16'h0, 0, 0, 0, 16'h0000, 16'h0, 16'h0);
        v[8]  = mk(32, 2'b00, 2'b10, 5'h01, 5'h04, 2'b10, 16'h0000, 16'h0001, 1, 0, 0, 16'h0001, 16'h0, 16'h0);
        v[9]  = mk(32, 2'b00, 2'b10, 5'h01, 5'h04, 2'b10, 16'h0000, 16'h0002, 1, 0, 0, 16'h0002, 16'h0, 16'h0);
        v[10] = mk(32, 2'b00, 2'b00, 5'h01, 5'h04, 2'b10, 16'hFFFF, 16'h0, 0, 0, 0, 16'hFFFF, 16'h0, 16'h0);
        v[11] = mk(32, 2'b00, 2'b10, 5'h01, 5'h04, 2'b10, 16'h0000, 16'hFFFF, 1, 0, 0, 16'h0000, 16'h0, 16'h0);
        v[12] = mk(32, 2'b00, 2'b01, 5'h02, 5'h04, 2'b10, 16'h1234, 16'h0, 0, 0, 0, 16'h0000, 16'h0, 16'h0);
        v[13] = mk(32, 2'b00, 2'b11, 5'h01, 5'h04, 2'b10, 16'h0000, 16'h0001, 1, 0, 0, 16'h0000, 16'h0, 16'h0);
        v[14] = mk(31, 2'b00, 2'b00, 5'h01, 5'h04, 2'b10, 16'h0005, 16'h0, 0, 0, 0, 16'h0000, 16'h0, 16'h0);
        v[15] = mk(32, 2'b01, 2'b01, 5'h01, 5'h04, 2'b10, 16'h0055, 16'h0, 0, 0, 0, 16'h0000, 16'h0, 16'h0);
        v[16] = mk(32, 2'b00, 2'b01, 5'h01, 5'h04, 2'b11, 16'hBAD0, 16'h0, 0, 0, 1, 16'h0000, 16'h0, 16'h0);
        v[17] = mk(32, 2'b00, 2'b11, 5'h01, 5'h04, 2'b10, 16'h0000, 16'h0001, 1, 0, 0, 16'h0000, 16'h0, 16'h0);
        v[18] = mk(32, 2'b00, 2'b00, 5'h01, 5'h04, 2'b10, 16'h000F, 16'h0, 0, 0, 0, 16'h000F, 16'h0, 16'h0);
        v[19] = mk(32, 2'b00, 2'b01, 5'h01, 5'h04, 2'b10, 16'h5A5A, 16'h0, 0, 1, 0, 16'h000F, 16'h000F, 16'h5A5A);
        v[20] = mk(32, 2'b00, 2'b11, 5'h01, 5'h04, 2'b10, 16'h0000, 16'h5A5A, 1, 0, 0, 16'h000F, 16'h0, 16'h0);
        v[21] = mk(32, 2'b00, 2'b00, 5'h01, 5'h04, 2'b10, 16'h0010, 16'h0, 0, 0, 0, 16'h0010, 16'h0, 16'h0);
        v[22] = mk(32, 2'b00, 2'b01, 5'h01, 5'h04, 2'b10, 16'h7777, 16'h0, 0, 0, 0, 16'h0010, 16'h0, 16'h0);
        v[23] = mk(32, 2'b00, 2'b11, 5'h01, 5'h04, 2'b10, 16'h0000, 16'hFFFF, 1, 0, 0, 16'h0010, 16'h0, 16'h0);
        v[24] = mk(32, 2'b00, 2'b11, 5'h02, 5'h04, 2'b10, 16'h0000, 16'h0, 0, 0, 0, 16'h0010, 16'h0, 16'h0);
        v[25] = mk(32, 2'b00, 2'b00, 5'h01, 5'h05, 2'b10, 16'h0009, 16'h0, 0, 0, 0, 16'h0010, 16'h0, 16'h0);
        v[26] = mk(32, 2'b00, 2'b00, 5'h01, 5'h04, 2'b10, 16'h0007, 16'h0, 0, 0, 0, 16'h0007, 16'h0, 16'h0);
        v[27] = mk(32, 2'b00, 2'b01, 5'h01, 5'h04, 2'b10, 16'h1357, 16'h0, 0, 1, 0, 16'h0007, 16'h0007, 16'h1357);
        v[28] = mk(32, 2'b00, 2'b11, 5'h01, 5'h04, 2'b10, 16'h0000, 16'h1357, 1, 0, 0, 16'h0007, 16'h0, 16'h0);
        v[29] = mk(32, 2'b00, 2'b00, 5'h01, 5'h04, 2'b10, 16'h0003, 16'h0, 0, 0, 0, 16'h0003, 16'h0, 16'h0);
        v[30] = mk(32, 2'b00, 2'b11, 5'h01, 5'h04, 2'b10, 16'h0000, 16'h0000, 1, 0, 0, 16'h0003, 16'h0, 16'h0);

        async_reset = 1'b0;
        mdc = 1'b0; st_oe = 1'b1; st_val = 1'b1;
        #22;
        chk("reset mdio_oe", mdio_oe, 1'b0);
        chk("reset mdio_o", mdio_o, 1'b1);
        chk("reset reg_wr", reg_wr, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset addr_reg", addr_reg, 16'h0000);
        #10 async_reset = 1'b1;
        #70;

        for (int i = 0; i < NV; i++) begin
            if (i == 26) reset_seq();
            run_vec(v[i], i);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
